// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
// Purpose: FSM state enum, lane/data widths and the list of legal byte-write
//          masks, plus a helper that checks a mask against that list.
// Ports:   none (package).
package dmem_pkg;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte, aligned halfword and full word masks are the only legal store shapes.
  localparam int N_LEGAL = 7;
  localparam logic [LANES-1:0] LEGAL_STRB [N_LEGAL] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic strb_legal(input logic [LANES-1:0] s);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL; i++) begin
      if (s == LEGAL_STRB[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - byte-writable word RAM with registered read data
// Purpose: 2^ADDR_W x 32 storage array, byte-enabled write, registered read.
// Ports:   clk, rst (async active-low, clears only the read register),
//          re/rindex (read enable and word index), we/windex/wdata (per-lane
//          write enables, word index, store data), rdata (registered output).
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] rindex,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] windex,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = mem[windex];
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (|we) mem[windex] <= merged;
  end

  // Read and write can land on the same edge when a zero-wait load follows a
  // store; the read then sees the freshly merged word (write-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (|we && (rindex == windex)) ? merged : mem[rindex];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
// Purpose: accepts one load/store at a time over req/addr_ok, answers with a
//          one-cycle data_ok after WAIT_CYCLES wait states, flags bad masks
//          and out-of-range addresses.
// Ports:   clk, rst (async active-low), req/wr/wstrb/addr/wdata (request),
//          addr_ok (accept), data_ok/rdata/err (response).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [LANES-1:0]  wstrb,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam state_t     ACCEPT_NEXT = (WAIT_CYCLES == 0) ? RESP : WAIT;

  function automatic logic range_err(input logic [31:2] a);
    return |a[31:ADDR_W+2];
  endfunction

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic [31:2]       l_addr;
  logic              l_wr;
  logic [LANES-1:0]  l_wstrb;
  logic [DATA_W-1:0] l_wdata;
  logic              zero_q;
  logic              hs;
  logic              l_range_err, l_strb_err;
  logic [31:2]       src_addr;
  logic              src_wr, src_range_err;
  logic              rd_load, re;
  logic [LANES-1:0]  we;
  logic [DATA_W-1:0] bank_rdata;
  logic              unused;

  assign unused = &{1'b0, addr[1:0]};

  assign hs          = req & addr_ok;
  assign l_range_err = range_err(l_addr);
  assign l_strb_err  = ~strb_legal(l_wstrb);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hs) next_state = ACCEPT_NEXT;
      WAIT:    if (cnt == 4'd0) next_state = RESP;
      RESP:    next_state = hs ? ACCEPT_NEXT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    addr_ok = 1'b0;
    data_ok = 1'b0;
    err     = 1'b0;
    addr_ok = (state != WAIT);
    data_ok = (state == RESP);
    err     = data_ok & (l_range_err | (l_wr & l_strb_err));
  end

  // Wait counter and request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      l_addr  <= '0;
      l_wr    <= 1'b0;
      l_wstrb <= '0;
      l_wdata <= '0;
    end else begin
      if (hs) begin
        cnt     <= WAIT_INIT;
        l_addr  <= addr[31:2];
        l_wr    <= wr;
        l_wstrb <= wstrb;
        l_wdata <= wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // The RAM read happens on the edge entering RESP. With zero wait states
  // that edge is the accepting edge, so the request has not been latched yet
  // and the live inputs must drive the read.
  assign src_addr      = (WAIT_CYCLES == 0) ? addr[31:2] : l_addr;
  assign src_wr        = (WAIT_CYCLES == 0) ? wr : l_wr;
  assign src_range_err = range_err(src_addr);
  assign rd_load       = (next_state == RESP) & ~src_wr;
  assign re            = rd_load & ~src_range_err;

  // Stores commit on the edge that ends RESP, using the latched request.
  assign we = (state == RESP && l_wr && !l_range_err && !l_strb_err) ? l_wstrb : '0;

  // Out-of-range loads read as zero; the flag holds alongside the bank's
  // read register so rdata stays stable until the next load response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         zero_q <= 1'b0;
    else if (rd_load) zero_q <= src_range_err;
  end

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .re     (re),
    .rindex (src_addr[ADDR_W+1:2]),
    .we     (we),
    .windex (l_addr[ADDR_W+1:2]),
    .wdata  (l_wdata),
    .rdata  (bank_rdata)
  );

  assign rdata = zero_q ? '0 : bank_rdata;

endmodule
